// File: rtl/counter_pkg.sv
// Shared constants for the up/down loadable counter.
// Direction encodings and the widest supported counter.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned COUNTER_MAX_WIDTH = 128;

endpackage

// File: rtl/counter_updown_load_if.sv
// Control and result bundle of the up/down loadable counter.
// master drives the controls, slave is the counter itself.
interface counter_updown_load_if #(
    parameter int unsigned WIDTH = 128
);

    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] result;
    logic             tc;

    modport master (
        output en,
        output up_down,
        output load,
        output load_value,
        input  result,
        input  tc
    );

    modport slave (
        input  en,
        input  up_down,
        input  load,
        input  load_value,
        output result,
        output tc
    );

endinterface

// File: rtl/counter_prescaler.sv
// Step-tick divider: one tick per PRESCALE enabled cycles.
// PRESCALE=1 is a pure wire from en; no count register exists.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    if (PRESCALE == 1) begin : g_direct
        // clk and reset have nothing to act on without a count register
        logic unused_inputs;
        assign unused_inputs = clk ^ reset;
        assign tick = en & ~clear;
    end else begin : g_divide
        localparam int unsigned CW = $clog2(PRESCALE);
        localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

        logic [CW-1:0] count;

        assign tick = en & ~clear & (count == LAST);

        // count enabled cycles; hold while en=0, restart on reset/load
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                count <= '0;
            end else if (en) begin
                count <= (count == LAST) ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_updown_load.sv
// Up/down counter with parallel load, prescaler and terminal count.
// Define COUNTER_SATURATE_EN to pin at the ends instead of wrapping.
module counter_updown_load
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned PRESCALE = 1
) (
    input logic clk,
    input logic reset,
    counter_updown_load_if.slave bus
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic             tick;
    logic [WIDTH-1:0] count;
    logic             tc_q;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(bus.load),
        .en   (bus.en),
        .tick (tick)
    );

    // priority: reset, load, step on tick, otherwise hold with tc low
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc_q  <= 1'b0;
        end else if (bus.load) begin
            count <= bus.load_value;
            tc_q  <= 1'b0;
        end else if (tick) begin
            if (bus.up_down == DIR_UP) begin
`ifdef COUNTER_SATURATE_EN
                if (count == ONES) begin
                    tc_q <= 1'b1;
                end else begin
                    count <= count + ONE;
                    tc_q  <= 1'b0;
                end
`else
                count <= count + ONE;
                tc_q  <= (count == ONES);
`endif
            end else begin
`ifdef COUNTER_SATURATE_EN
                if (count == '0) begin
                    tc_q <= 1'b1;
                end else begin
                    count <= count - ONE;
                    tc_q  <= 1'b0;
                end
`else
                count <= count - ONE;
                tc_q  <= (count == '0);
`endif
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.result = count;
    assign bus.tc     = tc_q;

endmodule

// File: tb/tb_counter_updown_load.sv
// Directed bench for counter_updown_load at WIDTH=8.
// Two instances (PRESCALE 1 and 4) share the same stimulus.
module tb_counter_updown_load;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] load_value;

    int vectors;
    int miscompares;

    counter_updown_load_if #(.WIDTH(8)) bus1 ();
    counter_updown_load_if #(.WIDTH(8)) bus4 ();

    assign bus1.en         = en;
    assign bus1.up_down    = up_down;
    assign bus1.load       = load;
    assign bus1.load_value = load_value;
    assign bus4.en         = en;
    assign bus4.up_down    = up_down;
    assign bus4.load       = load;
    assign bus4.load_value = load_value;

    counter_updown_load #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    counter_updown_load #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic [7:0] r,
                          input logic t);
        check({tag, " p1 result"}, 32'(bus1.result), 32'(r));
        check({tag, " p1 tc"}, 32'(bus1.tc), 32'(t));
    endtask

    task automatic check4(input string tag, input logic [7:0] r,
                          input logic t);
        check({tag, " p4 result"}, 32'(bus4.result), 32'(r));
        check({tag, " p4 tc"}, 32'(bus4.tc), 32'(t));
    endtask

    initial begin
        logic [7:0] exp_r;
        logic       exp_t;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        en          = 1'b0;
        up_down     = 1'b1;
        load        = 1'b0;
        load_value  = 8'h00;

        // reset state
        step();
        check1("reset", 8'h00, 1'b0);
        check4("reset", 8'h00, 1'b0);

        // free-running up count, wrap at 256
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
`ifdef COUNTER_SATURATE_EN
            exp_r = (i > 255) ? 8'hFF : 8'(i);
            exp_t = (i > 255);
`else
            exp_r = 8'(i);
            exp_t = (i == 256);
`endif
            check1("up", exp_r, exp_t);
        end

        // load 2 then count down through 0
        load       = 1'b1;
        load_value = 8'h02;
        step();
        check1("load2", 8'h02, 1'b0);
        load    = 1'b0;
        up_down = 1'b0;
        step();
        check1("down1", 8'h01, 1'b0);
        step();
        check1("down0", 8'h00, 1'b0);
        step();
`ifdef COUNTER_SATURATE_EN
        check1("down_sat", 8'h00, 1'b1);
`else
        check1("down_wrap", 8'hFF, 1'b1);
`endif
        en = 1'b0;
        step();
`ifdef COUNTER_SATURATE_EN
        check1("hold", 8'h00, 1'b0);
`else
        check1("hold", 8'hFF, 1'b0);
`endif

        // loading the boundary values never raises tc
        load       = 1'b1;
        load_value = 8'hFF;
        step();
        check1("loadFF", 8'hFF, 1'b0);
        load_value = 8'h00;
        step();
        check1("load00", 8'h00, 1'b0);
        load = 1'b0;

        // prescale 4 with en 1,1,0,1,1
        reset   = 1'b1;
        up_down = 1'b1;
        step();
        check4("rst2", 8'h00, 1'b0);
        reset = 1'b0;
        en    = 1'b1;
        step();
        check4("ps_e1", 8'h00, 1'b0);
        step();
        check4("ps_e2", 8'h00, 1'b0);
        en = 1'b0;
        step();
        check4("ps_hold", 8'h00, 1'b0);
        en = 1'b1;
        step();
        check4("ps_e3", 8'h00, 1'b0);
        step();
        check4("ps_tick", 8'h01, 1'b0);

        // load with en at prescaler=2 restarts the prescale period
        step();
        step();
        check4("ps_pre2", 8'h01, 1'b0);
        load       = 1'b1;
        load_value = 8'h7F;
        step();
        check4("ps_load", 8'h7F, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check4("ps_wait", 8'h7F, 1'b0);
        end
        step();
        check4("ps_tick2", 8'h80, 1'b0);

        // reset beats load, and drops partial prescale progress
        load       = 1'b1;
        load_value = 8'hC8;
        step();
        check1("load200", 8'hC8, 1'b0);
        check4("load200", 8'hC8, 1'b0);
        load = 1'b0;
        step();
        step();
        check1("pre_rst", 8'hCA, 1'b0);
        check4("pre_rst", 8'hC8, 1'b0);
        reset = 1'b1;
        load  = 1'b1;
        step();
        check1("rst_vs_load", 8'h00, 1'b0);
        check4("rst_vs_load", 8'h00, 1'b0);
        reset = 1'b0;
        load  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check4("post_rst", 8'h00, 1'b0);
        end
        step();
        check4("post_rst_tick", 8'h01, 1'b0);
        check1("post_rst", 8'h04, 1'b0);

`ifdef COUNTER_SATURATE_EN
        // pin at all-ones with tc on each blocked tick
        load       = 1'b1;
        load_value = 8'hFE;
        step();
        check1("sat_load", 8'hFE, 1'b0);
        load = 1'b0;
        step();
        check1("sat_t1", 8'hFF, 1'b0);
        step();
        check1("sat_t2", 8'hFF, 1'b1);
        step();
        check1("sat_t3", 8'hFF, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
